// File: rtl/clock_domain_import.sv
// Destination side of a toggle req/ack clock-domain-crossing handshake.
// Captured words are queued in a small FIFO and offered on a valid/ready stream.
module clock_domain_import #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] handshake_data,
  input  logic            handshake_req,
  output logic            handshake_ack,
  output logic [SIZE-1:0] data,
  output logic            stb,
  input  logic            ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]      req_ff_q, req_ff_d;
  logic            ack_q, ack_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            stb_q, stb_d;
  logic [SIZE-1:0] data_q, data_d;
  logic [SIZE-1:0] mem [DEPTH];

  logic req_sync;
  logic full;
  logic pending;
  logic capture;
  logic pop;

  assign req_sync = req_ff_q[0];
  assign full     = (count_q == CW'(DEPTH));
  assign pending  = (req_sync != ack_q);
  assign capture  = pending && !full;
  assign pop      = stb_q && ready;

  always_comb begin
    req_ff_d = {handshake_req, req_ff_q[1]};
    ack_d    = capture ? req_sync : ack_q;
    wr_ptr_d = wr_ptr_q + PW'(capture);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    count_d = count_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The new head may be the word being written this very cycle, so bypass memory.
    stb_d  = (count_d != '0);
    data_d = '0;
    if (count_d != '0) begin
      if (capture && (rd_ptr_d == wr_ptr_q)) begin
        data_d = handshake_data;
      end else begin
        data_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ff_q <= '0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stb_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      req_ff_q <= req_ff_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stb_q    <= stb_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_q] <= handshake_data;
    end
  end

  assign handshake_ack = ack_q;
  assign stb           = stb_q;
  assign data          = data_q;

endmodule

// File: tb/tb_clock_domain_import.sv
// Directed bench for clock_domain_import: acts as the source-side handshake
// partner and as the downstream consumer, comparing against hand-computed values.
module tb_clock_domain_import;

  logic       clk;
  logic       rst;
  logic [7:0] handshake_data;
  logic       handshake_req;
  logic       handshake_ack;
  logic [7:0] data;
  logic       stb;
  logic       ready;

  int checkCount;
  int errorCount;

  clock_domain_import #(.SIZE(8), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .handshake_data (handshake_data),
    .handshake_req  (handshake_req),
    .handshake_ack  (handshake_ack),
    .data           (data),
    .stb            (stb),
    .ready          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Source side: present a word and toggle the request (called at a negedge).
  task automatic applyStimulus(input logic [7:0] word);
    handshake_data = word;
    handshake_req  = ~handshake_req;
  endtask

  task automatic waitAck(input string tag, input int budget, output int waited);
    waited = 0;
    while (handshake_ack != handshake_req && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(tag, handshake_ack, handshake_req);
  endtask

  // Consume n words, expecting the consecutive values first, first+1, ...
  task automatic drainExpect(input string tag, input logic [7:0] first, input int n);
    int idx = 0;
    int cyc = 0;
    ready = 1'b1;
    while (idx < n && cyc < 100) begin
      if (stb) begin
        checkOutput(tag, data, 32'(first) + 32'(idx));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    checkOutput({tag, "_count"}, idx, n);
    checkOutput({tag, "_empty"}, stb, 0);
  endtask

  initial begin
    int   waited;
    logic expAck;
    checkCount     = 0;
    errorCount     = 0;
    rst            = 1'b1;
    handshake_req  = 1'b0;
    handshake_data = 8'h00;
    ready          = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_ack", handshake_ack, 0);
      checkOutput("idle_stb", stb, 0);
      checkOutput("idle_data", data, 0);
    end

    // Single word with latency check, then a single pop
    applyStimulus(8'hA5);
    waitAck("t2_ack", 10, waited);
    checkOutput("t2_latency_le3", waited <= 3, 1);
    checkOutput("t2_stb", stb, 1);
    checkOutput("t2_data", data, 8'hA5);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checkOutput("t2_stb_after_pop", stb, 0);

    // Fill to DEPTH with the consumer stalled, fifth request must stay unacked
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(8'(i));
      waitAck("t3_ack", 10, waited);
    end
    expAck = handshake_ack;
    applyStimulus(8'h05);
    repeat (8) @(negedge clk);
    checkOutput("t3_fifth_held", handshake_ack, expAck);
    checkOutput("t3_head_stb", stb, 1);
    checkOutput("t3_head_data", data, 8'h01);
    drainExpect("t3_order", 8'h01, 5);
    checkOutput("t3_fifth_acked", handshake_ack, handshake_req);

    // Continuous streaming, pointers wrap several times
    ready = 1'b1;
    fork
      begin
        int w;
        for (int i = 0; i < 16; i++) begin
          applyStimulus(8'(8'h10 + i));
          waitAck("t4_ack", 10, w);
        end
      end
      begin
        int idx = 0;
        for (int c = 0; c < 600 && idx < 16; c++) begin
          @(negedge clk);
          if (stb) begin
            checkOutput("t4_data", data, 32'h10 + 32'(idx));
            idx++;
          end
        end
        checkOutput("t4_count", idx, 16);
      end
    join
    repeat (3) @(negedge clk);
    ready = 1'b0;
    checkOutput("t4_empty", stb, 0);

    // Full FIFO with a pending request and a one-cycle ready pulse
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'(8'h20 + i));
      waitAck("t5_fill_ack", 10, waited);
    end
    expAck = handshake_ack;
    applyStimulus(8'h24);
    repeat (6) @(negedge clk);
    checkOutput("t5_held", handshake_ack, expAck);
    checkOutput("t5_head", data, 8'h20);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checkOutput("t5_no_capture_on_pop", handshake_ack, expAck);
    checkOutput("t5_new_head", data, 8'h21);
    @(negedge clk);
    checkOutput("t5_capture_next", handshake_ack, handshake_req);
    drainExpect("t5_order", 8'h21, 4);

    // Reset with words queued and a request pending
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'(8'h30 + i));
      waitAck("t6_fill_ack", 10, waited);
    end
    applyStimulus(8'h33);
    checkOutput("t6_req_high", handshake_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_stb", stb, 0);
    checkOutput("t6_rst_ack", handshake_ack, 0);
    checkOutput("t6_rst_data", data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    waitAck("t6_post_ack", 10, waited);
    checkOutput("t6_post_ack_val", handshake_ack, 1);
    checkOutput("t6_post_stb", stb, 1);
    checkOutput("t6_post_data", data, 8'h33);
    drainExpect("t6_single", 8'h33, 1);
    repeat (10) @(negedge clk);
    checkOutput("t6_no_second_capture", stb, 0);
    checkOutput("t6_ack_stable", handshake_ack, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
